// File: rtl/main_memory_ctrl.sv
// Main-memory slave for the microprogrammed datapath: word-organised synchronous
// array behind a RD/WR level handshake with programmable wait states and a one-cycle ACK.
module main_memory_ctrl #(
    parameter int unsigned DATAWIDTH_BUS         = 32,
    parameter int unsigned DATAWIDTH_MEM_ADDRESS = 10,
    parameter int unsigned WAIT_STATES           = 2
) (
    input  logic                     MAIN_MEMORY_CTRL_CLOCK_50,
    input  logic                     MAIN_MEMORY_CTRL_ResetInHigh_In,
    input  logic                     MAIN_MEMORY_CTRL_RD_In,
    input  logic                     MAIN_MEMORY_CTRL_WR_In,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_CTRL_Address_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_CTRL_DataIn_InBus,
    output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_CTRL_DataOut_OutBus,
    output logic                     MAIN_MEMORY_CTRL_ACK_Out,
    output logic                     MAIN_MEMORY_CTRL_Busy_Out,
    output logic                     MAIN_MEMORY_CTRL_Error_Out
);
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned AW        = DATAWIDTH_MEM_ADDRESS;
    localparam int unsigned DW        = DATAWIDTH_BUS;
    localparam int unsigned MEM_WORDS = 2 ** AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } stateT;

    logic          clk;
    logic          rst;
    stateT         state;
    stateT         stateNext;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;

    logic          req;
    logic          illegalReq;
    logic [AW-1:0] wordIdx;
    logic [DW-1:0] dataLatched;
    logic          opRead;
    logic          opWrite;
    logic          opError;

    logic          ackNext;
    logic          busyNext;
    logic          errorNext;
    logic          accessNow;
    logic          memWe;
    logic          readLoad;

    logic [DW-1:0] mem [0:MEM_WORDS-1];
    logic          unusedAddrHi;

    assign clk          = MAIN_MEMORY_CTRL_CLOCK_50;
    assign rst          = MAIN_MEMORY_CTRL_ResetInHigh_In;
    assign req          = MAIN_MEMORY_CTRL_RD_In | MAIN_MEMORY_CTRL_WR_In;
    assign illegalReq   = (MAIN_MEMORY_CTRL_Address_InBus[1:0] != 2'b00)
                        | (MAIN_MEMORY_CTRL_RD_In & MAIN_MEMORY_CTRL_WR_In);
    // Address bits above the word index wrap the array and are deliberately ignored.
    assign unusedAddrHi = ^MAIN_MEMORY_CTRL_Address_InBus[DW-1:AW+2];

    // State register and registered outputs; reset wins over everything on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                           <= ST_IDLE;
            waitCnt                         <= '0;
            MAIN_MEMORY_CTRL_DataOut_OutBus <= '0;
            MAIN_MEMORY_CTRL_ACK_Out        <= 1'b0;
            MAIN_MEMORY_CTRL_Busy_Out       <= 1'b0;
            MAIN_MEMORY_CTRL_Error_Out      <= 1'b0;
        end else begin
            state                      <= stateNext;
            waitCnt                    <= waitCntNext;
            MAIN_MEMORY_CTRL_ACK_Out   <= ackNext;
            MAIN_MEMORY_CTRL_Busy_Out  <= busyNext;
            MAIN_MEMORY_CTRL_Error_Out <= errorNext;
            if (readLoad) begin
                MAIN_MEMORY_CTRL_DataOut_OutBus <= mem[wordIdx];
            end
        end
    end

    // Next-state and wait counter.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    stateNext   = ST_BUSY;
                    waitCntNext = CNT_W'(WAIT_STATES);
                end
            end
            ST_BUSY: begin
                if (waitCnt != '0) begin
                    waitCntNext = waitCnt - CNT_W'(1);
                end else begin
                    stateNext = ST_ACK;
                end
            end
            ST_ACK:  stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Output decode: next-cycle flags plus the access strobes for the BUSY->ACK edge.
    always_comb begin
        busyNext  = (stateNext == ST_BUSY);
        ackNext   = (stateNext == ST_ACK);
        errorNext = ackNext & opError;
        accessNow = (state == ST_BUSY) && (waitCnt == '0);
        memWe     = accessNow & opWrite;
        readLoad  = accessNow & opRead;
    end

    // Request capture in IDLE so bus activity during BUSY cannot disturb the access.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            wordIdx     <= MAIN_MEMORY_CTRL_Address_InBus[AW+1:2];
            dataLatched <= MAIN_MEMORY_CTRL_DataIn_InBus;
            opRead      <= MAIN_MEMORY_CTRL_RD_In & ~illegalReq;
            opWrite     <= MAIN_MEMORY_CTRL_WR_In & ~illegalReq;
            opError     <= illegalReq;
        end
    end

    // Storage array; contents survive reset, but a reset on the commit edge aborts the write.
    always_ff @(posedge clk) begin
        if (!rst && memWe) begin
            mem[wordIdx] <= dataLatched;
        end
    end

endmodule
